// File: rtl/bp_common_pkg.sv
// rtl/bp_common_pkg.sv - FE command types plus branch-statistics FSM and counter-index enums
package bp_common_pkg;

    typedef enum logic [2:0] {
        e_op_state_reset         = 3'd0,
        e_op_pc_redirection      = 3'd1,
        e_op_attaboy             = 3'd2,
        e_op_icache_fence        = 3'd3,
        e_op_itlb_fill_response  = 3'd4,
        e_op_itlb_fence          = 3'd5
    } bp_fe_command_queue_opcode_e;

    typedef enum logic [1:0] {
        e_stat_idle  = 2'd0,
        e_stat_run   = 2'd1,
        e_stat_halt  = 2'd2,
        e_stat_drain = 2'd3
    } bp_stat_state_e;

    typedef enum logic [3:0] {
        e_cnt_instr    = 4'd0,
        e_cnt_attaboy  = 4'd1,
        e_cnt_redirect = 4'd2,
        e_cnt_br       = 4'd3,
        e_cnt_jal      = 4'd4,
        e_cnt_jalr     = 4'd5,
        e_cnt_ret      = 4'd6,
        e_cnt_btb_hit  = 4'd7,
        e_cnt_ras_hit  = 4'd8,
        e_cnt_br_miss  = 4'd9
    } bp_stat_cnt_e;

    localparam int stat_num_lp = 10;

endpackage

// File: rtl/bp_sat_counter.sv
// rtl/bp_sat_counter.sv - saturating up-counter with synchronous clear
module bp_sat_counter #(
    parameter int width_p = 32
) (
    input  logic               clk_i,
    input  logic               reset_li,
    input  logic               clr_i,
    input  logic               inc_i,
    output logic [width_p-1:0] count_o
);

    logic [width_p-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i)
            count_d = '0;
        else if (inc_i && (count_q != '1))
            count_d = count_q + width_p'(1);
    end

    always_ff @(posedge clk_i or negedge reset_li) begin
        if (!reset_li)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/bp_branch_stat_ctrl.sv
// rtl/bp_branch_stat_ctrl.sv - branch-predictor statistics counters with run/halt control and drain stream
module bp_branch_stat_ctrl
    import bp_common_pkg::*;
#(
    parameter int cnt_width_p = 32,
    parameter int num_stat_p  = 10
) (
    input  logic                   clk_i,
    input  logic                   reset_li,
    input  logic                   start_i,
    input  logic                   stop_i,
    input  logic                   clear_i,
    input  logic                   dump_i,
    input  logic [cnt_width_p-1:0] window_i,
    input  logic                   commit_v_i,
    input  logic                   attaboy_v_i,
    input  logic                   redirect_v_i,
    input  logic                   br_miss_v_i,
    input  logic                   is_br_i,
    input  logic                   is_jal_i,
    input  logic                   is_jalr_i,
    input  logic                   is_ret_i,
    input  logic                   src_btb_i,
    input  logic                   src_ret_i,
    output logic                   data_v_o,
    output logic [cnt_width_p-1:0] data_o,
    output logic [3:0]             data_idx_o,
    output logic                   data_last_o,
    input  logic                   data_ready_i,
    output logic [1:0]             state_o,
    output logic                   done_o,
    output logic                   err_o
);

    bp_stat_state_e         state_q, state_d;
    logic [cnt_width_p-1:0] window_q, window_d;
    logic [3:0]             idx_q, idx_d;
    logic                   err_q, err_d;

    logic [cnt_width_p-1:0] cnt_lo [num_stat_p];
    logic [num_stat_p-1:0]  inc_li;
    logic                   clr_li;
    logic                   in_run, in_drain, idle_or_halt;
    logic                   ab_only, meta_v, window_hit;

    assign in_run       = (state_q == e_stat_run);
    assign in_drain     = (state_q == e_stat_drain);
    assign idle_or_halt = (state_q == e_stat_idle) || (state_q == e_stat_halt);

    // Start zeroes the counters as well as clear; both only act outside RUN/DRAIN.
    assign clr_li = idle_or_halt & (start_i | clear_i);

    // A collision counts only the redirect; metadata belongs to whichever event survives.
    assign ab_only = attaboy_v_i & ~redirect_v_i;
    assign meta_v  = ab_only | redirect_v_i;

    always_comb begin
        inc_li = '0;
        if (in_run) begin
            inc_li[e_cnt_instr]    = commit_v_i;
            inc_li[e_cnt_attaboy]  = ab_only;
            inc_li[e_cnt_redirect] = redirect_v_i;
            inc_li[e_cnt_br]       = meta_v & is_br_i;
            inc_li[e_cnt_jal]      = meta_v & is_jal_i;
            inc_li[e_cnt_jalr]     = meta_v & is_jalr_i;
            inc_li[e_cnt_ret]      = meta_v & is_ret_i;
            inc_li[e_cnt_btb_hit]  = meta_v & src_btb_i;
            inc_li[e_cnt_ras_hit]  = meta_v & src_ret_i;
            inc_li[e_cnt_br_miss]  = redirect_v_i & br_miss_v_i;
        end
    end

    for (genvar i = 0; i < num_stat_p; i++) begin : g_cnt
        bp_sat_counter #(
            .width_p (cnt_width_p)
        ) u_cnt (
            .clk_i    (clk_i),
            .reset_li (reset_li),
            .clr_i    (clr_li),
            .inc_i    (inc_li[i]),
            .count_o  (cnt_lo[i])
        );
    end

    // Halt in the same cycle the commit that reaches the budget is counted.
    assign window_hit = in_run && commit_v_i && (window_q != '0)
                     && (cnt_lo[e_cnt_instr] != '1)
                     && ((cnt_lo[e_cnt_instr] + cnt_width_p'(1)) == window_q);

    always_comb begin
        state_d  = state_q;
        window_d = window_q;
        idx_d    = idx_q;
        err_d    = err_q;
        if (in_run && attaboy_v_i && redirect_v_i)
            err_d = 1'b1;
        case (state_q)
            e_stat_idle: begin
                if (start_i) begin
                    state_d  = e_stat_run;
                    window_d = window_i;
                    err_d    = 1'b0;
                end
            end
            e_stat_run: begin
                if (stop_i || window_hit)
                    state_d = e_stat_halt;
            end
            e_stat_halt: begin
                if (start_i) begin
                    state_d  = e_stat_run;
                    window_d = window_i;
                    err_d    = 1'b0;
                end else if (dump_i) begin
                    state_d = e_stat_drain;
                    idx_d   = 4'd0;
                end
            end
            e_stat_drain: begin
                if (data_ready_i) begin
                    if (idx_q == e_cnt_br_miss) begin
                        state_d = e_stat_halt;
                        idx_d   = 4'd0;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: state_d = e_stat_idle;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_li) begin
        if (!reset_li) begin
            state_q  <= e_stat_idle;
            window_q <= '0;
            idx_q    <= 4'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            window_q <= window_d;
            idx_q    <= idx_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        data_o = '0;
        if (in_drain && (int'(idx_q) < num_stat_p))
            data_o = cnt_lo[idx_q];
    end

    assign state_o     = state_q;
    assign done_o      = (state_q == e_stat_halt);
    assign err_o       = err_q;
    assign data_v_o    = in_drain;
    assign data_idx_o  = idx_q;
    assign data_last_o = in_drain && (idx_q == e_cnt_br_miss);

endmodule

// File: tb/tb_bp_branch_stat_ctrl.sv
// tb/tb_bp_branch_stat_ctrl.sv - directed self-checking bench for bp_branch_stat_ctrl
module tb_bp_branch_stat_ctrl;

    logic        clk_i = 1'b0;
    logic        reset_li;
    logic        start_i, stop_i, clear_i, dump_i;
    logic [31:0] window_i;
    logic        commit_v_i, attaboy_v_i, redirect_v_i, br_miss_v_i;
    logic        is_br_i, is_jal_i, is_jalr_i, is_ret_i, src_btb_i, src_ret_i;
    logic        data_ready_i;

    logic        data_v_o, data_last_o, done_o, err_o;
    logic [31:0] data_o;
    logic [3:0]  data_idx_o;
    logic [1:0]  state_o;

    logic        d4_data_v_o, d4_data_last_o, d4_done_o, d4_err_o;
    logic [3:0]  d4_data_o;
    logic [3:0]  d4_data_idx_o;
    logic [1:0]  d4_state_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_a [10];

    always #5 clk_i = ~clk_i;

    bp_branch_stat_ctrl #(.cnt_width_p(32), .num_stat_p(10)) dut (
        .clk_i(clk_i), .reset_li(reset_li),
        .start_i(start_i), .stop_i(stop_i), .clear_i(clear_i), .dump_i(dump_i),
        .window_i(window_i),
        .commit_v_i(commit_v_i), .attaboy_v_i(attaboy_v_i), .redirect_v_i(redirect_v_i),
        .br_miss_v_i(br_miss_v_i),
        .is_br_i(is_br_i), .is_jal_i(is_jal_i), .is_jalr_i(is_jalr_i), .is_ret_i(is_ret_i),
        .src_btb_i(src_btb_i), .src_ret_i(src_ret_i),
        .data_v_o(data_v_o), .data_o(data_o), .data_idx_o(data_idx_o),
        .data_last_o(data_last_o), .data_ready_i(data_ready_i),
        .state_o(state_o), .done_o(done_o), .err_o(err_o)
    );

    bp_branch_stat_ctrl #(.cnt_width_p(4), .num_stat_p(10)) dut4 (
        .clk_i(clk_i), .reset_li(reset_li),
        .start_i(start_i), .stop_i(stop_i), .clear_i(clear_i), .dump_i(dump_i),
        .window_i(window_i[3:0]),
        .commit_v_i(commit_v_i), .attaboy_v_i(attaboy_v_i), .redirect_v_i(redirect_v_i),
        .br_miss_v_i(br_miss_v_i),
        .is_br_i(is_br_i), .is_jal_i(is_jal_i), .is_jalr_i(is_jalr_i), .is_ret_i(is_ret_i),
        .src_btb_i(src_btb_i), .src_ret_i(src_ret_i),
        .data_v_o(d4_data_v_o), .data_o(d4_data_o), .data_idx_o(d4_data_idx_o),
        .data_last_o(d4_data_last_o), .data_ready_i(data_ready_i),
        .state_o(d4_state_o), .done_o(d4_done_o), .err_o(d4_err_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pulses dump from HALT and walks all ten beats with ready held high.
    task automatic drain_check(input string tag, input logic [31:0] exp[10]);
        dump_i = 1'b1;
        tick();
        dump_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk({tag, "_v"},    {31'd0, data_v_o},    32'd1);
            chk({tag, "_idx"},  {28'd0, data_idx_o},  32'(i));
            chk({tag, "_data"}, data_o,               exp[i]);
            chk({tag, "_last"}, {31'd0, data_last_o}, (i == 9) ? 32'd1 : 32'd0);
            tick();
        end
        chk({tag, "_end_state"}, {30'd0, state_o}, 32'd2);
    endtask

    initial begin
        reset_li = 1'b0;
        start_i = 0; stop_i = 0; clear_i = 0; dump_i = 0;
        window_i = 0;
        commit_v_i = 0; attaboy_v_i = 0; redirect_v_i = 0; br_miss_v_i = 0;
        is_br_i = 0; is_jal_i = 0; is_jalr_i = 0; is_ret_i = 0; src_btb_i = 0; src_ret_i = 0;
        data_ready_i = 1'b1;

        #3;
        chk("rst_state", {30'd0, state_o}, 32'd0);
        chk("rst_done",  {31'd0, done_o}, 32'd0);
        chk("rst_err",   {31'd0, err_o}, 32'd0);
        chk("rst_dv",    {31'd0, data_v_o}, 32'd0);
        chk("rst_last",  {31'd0, data_last_o}, 32'd0);
        chk("rst_idx",   {28'd0, data_idx_o}, 32'd0);
        chk("rst_data",  data_o, 32'd0);

        tick();
        reset_li = 1'b1;
        tick();

        // stop/dump in IDLE do nothing
        dump_i = 1; stop_i = 1;
        tick();
        dump_i = 0; stop_i = 0;
        chk("idle_ignore", {30'd0, state_o}, 32'd0);

        // window of 5 with 7 commits offered
        window_i = 5; start_i = 1;
        tick();
        start_i = 0; window_i = 0;
        chk("win_run", {30'd0, state_o}, 32'd1);
        commit_v_i = 1;
        repeat (4) tick();
        chk("win_run4", {30'd0, state_o}, 32'd1);
        tick();
        chk("win_halt", {30'd0, state_o}, 32'd2);
        chk("win_done", {31'd0, done_o}, 32'd1);
        repeat (2) tick();
        commit_v_i = 0;
        chk("win_stay", {30'd0, state_o}, 32'd2);
        exp_a = '{32'd5, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        drain_check("win", exp_a);

        // attaboys and redirects with metadata
        start_i = 1;
        tick();
        start_i = 0;
        attaboy_v_i = 1; is_br_i = 1; src_btb_i = 1;
        repeat (3) tick();
        attaboy_v_i = 0; is_br_i = 0; src_btb_i = 0;
        redirect_v_i = 1; br_miss_v_i = 1; is_jalr_i = 1;
        repeat (2) tick();
        redirect_v_i = 0; br_miss_v_i = 0; is_jalr_i = 0;
        stop_i = 1;
        tick();
        stop_i = 0;
        chk("mix_halt", {30'd0, state_o}, 32'd2);
        exp_a = '{32'd0, 32'd3, 32'd2, 32'd3, 32'd0, 32'd2, 32'd0, 32'd3, 32'd0, 32'd2};
        drain_check("mix", exp_a);

        // attaboy/redirect collision
        start_i = 1;
        tick();
        start_i = 0;
        attaboy_v_i = 1; redirect_v_i = 1;
        tick();
        attaboy_v_i = 0; redirect_v_i = 0;
        chk("col_err", {31'd0, err_o}, 32'd1);
        stop_i = 1;
        tick();
        stop_i = 0;
        chk("col_err_halt", {31'd0, err_o}, 32'd1);
        exp_a = '{32'd0, 32'd0, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        drain_check("col", exp_a);
        start_i = 1;
        tick();
        start_i = 0;
        chk("col_err_clr", {31'd0, err_o}, 32'd0);
        stop_i = 1;
        tick();
        stop_i = 0;

        // 4-bit instance saturates at 15 with unbounded window
        start_i = 1;
        tick();
        start_i = 0;
        commit_v_i = 1;
        repeat (20) tick();
        commit_v_i = 0;
        stop_i = 1;
        tick();
        stop_i = 0;
        dump_i = 1;
        tick();
        dump_i = 0;
        chk("sat_d4", {28'd0, d4_data_o}, 32'd15);
        chk("sat_d32", data_o, 32'd20);
        repeat (10) tick();
        chk("sat_end", {30'd0, state_o}, 32'd2);

        // drain stall at idx4, then async reset mid-drain
        start_i = 1;
        tick();
        start_i = 0;
        attaboy_v_i = 1; is_jal_i = 1;
        repeat (4) tick();
        attaboy_v_i = 0; is_jal_i = 0;
        stop_i = 1;
        tick();
        stop_i = 0;
        dump_i = 1;
        tick();
        dump_i = 0;
        repeat (4) tick();
        data_ready_i = 0;
        chk("stall_idx", {28'd0, data_idx_o}, 32'd4);
        chk("stall_data", data_o, 32'd4);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("hold_idx", {28'd0, data_idx_o}, 32'd4);
            chk("hold_data", data_o, 32'd4);
            chk("hold_v", {31'd0, data_v_o}, 32'd1);
        end
        #2;
        reset_li = 0;
        #1;
        chk("mrst_state", {30'd0, state_o}, 32'd0);
        chk("mrst_done",  {31'd0, done_o}, 32'd0);
        chk("mrst_err",   {31'd0, err_o}, 32'd0);
        chk("mrst_dv",    {31'd0, data_v_o}, 32'd0);
        chk("mrst_last",  {31'd0, data_last_o}, 32'd0);
        chk("mrst_idx",   {28'd0, data_idx_o}, 32'd0);
        chk("mrst_data",  data_o, 32'd0);
        data_ready_i = 1;
        tick();
        reset_li = 1;
        tick();

        // stop with final commit; clear ignored in RUN
        start_i = 1;
        tick();
        start_i = 0;
        commit_v_i = 1; clear_i = 1;
        tick();
        clear_i = 0;
        tick();
        stop_i = 1;
        tick();
        stop_i = 0; commit_v_i = 0;
        chk("stopc_halt", {30'd0, state_o}, 32'd2);
        exp_a = '{32'd3, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        drain_check("stopc", exp_a);
        clear_i = 1;
        tick();
        clear_i = 0;
        exp_a = '{32'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        drain_check("clr", exp_a);
        start_i = 1; dump_i = 1;
        tick();
        start_i = 0; dump_i = 0;
        chk("start_prio", {30'd0, state_o}, 32'd1);
        stop_i = 1;
        tick();
        stop_i = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
